apb_reg_completer: RTL and testbench



---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_strb_merge.sv | 18 +
 rtl/apb_reg_completer.sv | 147 ++++++++++++++
 tb/tb_apb_reg_completer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, PPROT bit positions and sizing helpers.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apbState_e;

  localparam int PPROT_PRIV   = 0;
  localparam int PPROT_NONSEC = 1;
  localparam int PPROT_INSTR  = 2;

  // Index width of a register bank; a single-entry bank still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane merge: each strobed lane takes the new byte, the rest keep the old word.
module apb_strb_merge #(
  parameter int APB_DW = 32
) (
  input  logic [APB_DW-1:0]   oldWord,
  input  logic [APB_DW-1:0]   newWord,
  input  logic [APB_DW/8-1:0] strb,
  output logic [APB_DW-1:0]   mergedWord
);

  always_comb begin
    mergedWord = oldWord;
    for (int b = 0; b < APB_DW/8; b++) begin
      if (strb[b]) mergedWord[8*b +: 8] = newWord[8*b +: 8];
    end
  end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer fronting a bank of byte-strobed registers with configurable wait
// states and PSLVERR for out-of-range or unprivileged accesses.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int PRIV_REG0   = 1,
  localparam int APB_SW     = APB_DW / 8
) (
  input  logic                         ckApb,
  input  logic                         srstApb,
  input  logic [APB_AW-1:0]            apbPAddr,
  input  logic [2:0]                   apbPProt,
  input  logic                         apbPSel,
  input  logic                         apbPEnable,
  input  logic                         apbPWrite,
  input  logic [APB_DW-1:0]            apbPWData,
  input  logic [APB_SW-1:0]            apbPStrb,
  output logic [APB_DW-1:0]            apbPRData,
  output logic                         apbPSlvErr,
  output logic                         apbPReady,
  output logic [NUM_REGS*APB_DW-1:0]   regQ,
  output logic [NUM_REGS-1:0]          regWrPulse
);

  localparam int LSB   = $clog2(APB_SW);
  localparam int IDX_W = clog2_min1(NUM_REGS);
  localparam int HI    = LSB + IDX_W;

  apbState_e         state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  latIdx;
  logic              latWrite;
  logic              latErr;
  logic [APB_DW-1:0] latWData;
  logic [APB_SW-1:0] latStrb;
  logic [APB_DW-1:0] regs [NUM_REGS];

  logic [IDX_W-1:0]  reqIdx;
  logic              upperBad, idxBad, privBad, reqErr;
  logic [APB_DW-1:0] rdIdle, rdLat, mergedWord;
  logic              commit;
  logic              unusedBits;

  assign reqIdx     = apbPAddr[LSB +: IDX_W];
  assign unusedBits = ^{apbPProt, apbPAddr};

  generate
    if (HI >= APB_AW) begin : gNoUpper
      assign upperBad = 1'b0;
    end else begin : gUpper
      assign upperBad = |(apbPAddr >> HI);
    end
  endgenerate

  assign idxBad  = int'(reqIdx) >= NUM_REGS;
  assign privBad = (PRIV_REG0 != 0) && apbPWrite && (reqIdx == '0) && !apbPProt[PPROT_PRIV];
  assign reqErr  = upperBad | idxBad | privBad;

  // Read data is only ever presented for a clean read; errored reads return zero.
  assign rdIdle = (!apbPWrite && !reqErr) ? regs[reqIdx] : '0;
  assign rdLat  = (!latWrite && !latErr)  ? regs[latIdx] : '0;

  assign commit = (state == ST_DONE) && apbPSel && apbPEnable &&
                  latWrite && !latErr && (|latStrb);

  apb_strb_merge #(.APB_DW(APB_DW)) uMerge (
    .oldWord    (regs[latIdx]),
    .newWord    (latWData),
    .strb       (latStrb),
    .mergedWord (mergedWord)
  );

  always_ff @(posedge ckApb) begin
    if (srstApb) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      latIdx     <= '0;
      latWrite   <= 1'b0;
      latErr     <= 1'b0;
      latWData   <= '0;
      latStrb    <= '0;
      apbPReady  <= 1'b0;
      apbPSlvErr <= 1'b0;
      apbPRData  <= '0;
      regWrPulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      regWrPulse <= '0;
      case (state)
        ST_IDLE: begin
          if (apbPSel && !apbPEnable) begin
            latIdx   <= reqIdx;
            latWrite <= apbPWrite;
            latErr   <= reqErr;
            latWData <= apbPWData;
            latStrb  <= apbPStrb;
            cnt      <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state      <= ST_DONE;
              apbPReady  <= 1'b1;
              apbPSlvErr <= reqErr;
              apbPRData  <= rdIdle;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!apbPSel) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state      <= ST_DONE;
              apbPReady  <= 1'b1;
              apbPSlvErr <= latErr;
              apbPRData  <= rdLat;
            end
          end
        end
        ST_DONE: begin
          // Completion or abort: either way the response is torn down here.
          state      <= ST_IDLE;
          apbPReady  <= 1'b0;
          apbPSlvErr <= 1'b0;
          apbPRData  <= '0;
          if (commit) begin
            regs[latIdx]       <= mergedWord;
            regWrPulse[latIdx] <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : gRegQ
      assign regQ[i*APB_DW +: APB_DW] = regs[i];
    end
  endgenerate

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer: three instances with 0, 3 and 2 wait states.
module tb_apb_reg_completer;

  logic        ckApb = 1'b0;
  logic        srstApb;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic        selA   [3];
  logic [31:0] rdataA [3];
  logic        readyA [3];
  logic        errA   [3];
  logic [511:0] regQA [3];
  logic [15:0] pulseA [3];

  int checks = 0;
  int failures = 0;

  always #5 ckApb = ~ckApb;

  apb_reg_completer #(.WAIT_CYCLES(0)) u0 (
    .ckApb(ckApb), .srstApb(srstApb), .apbPAddr(paddr), .apbPProt(pprot),
    .apbPSel(selA[0]), .apbPEnable(penable), .apbPWrite(pwrite), .apbPWData(pwdata),
    .apbPStrb(pstrb), .apbPRData(rdataA[0]), .apbPSlvErr(errA[0]), .apbPReady(readyA[0]),
    .regQ(regQA[0]), .regWrPulse(pulseA[0]));

  apb_reg_completer #(.WAIT_CYCLES(3)) u3 (
    .ckApb(ckApb), .srstApb(srstApb), .apbPAddr(paddr), .apbPProt(pprot),
    .apbPSel(selA[1]), .apbPEnable(penable), .apbPWrite(pwrite), .apbPWData(pwdata),
    .apbPStrb(pstrb), .apbPRData(rdataA[1]), .apbPSlvErr(errA[1]), .apbPReady(readyA[1]),
    .regQ(regQA[1]), .regWrPulse(pulseA[1]));

  apb_reg_completer #(.WAIT_CYCLES(2)) u2 (
    .ckApb(ckApb), .srstApb(srstApb), .apbPAddr(paddr), .apbPProt(pprot),
    .apbPSel(selA[2]), .apbPEnable(penable), .apbPWrite(pwrite), .apbPWData(pwdata),
    .apbPStrb(pstrb), .apbPRData(rdataA[2]), .apbPSlvErr(errA[2]), .apbPReady(readyA[2]),
    .regQ(regQA[2]), .regWrPulse(pulseA[2]));

  typedef struct {
    int          dut;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] expData;
    logic        expErr;
    int          expCyc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic setup(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
    @(posedge ckApb); #1;
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
    penable = 1'b0; selA[d] = 1'b1;
    @(posedge ckApb); #1;
    penable = 1'b1;
  endtask

  // Full transfer; returns at #1 after the completing edge with the bus idle.
  task automatic apbXfer(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                         output logic [31:0] rd, output logic er, output int cyc, output bit got);
    setup(d, wr, addr, wdata, strb, prot);
    cyc = 0; got = 1'b0; rd = '0; er = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge ckApb);
      cyc++;
      if (readyA[d]) begin
        got = 1'b1; rd = rdataA[d]; er = errA[d];
      end else begin
        @(posedge ckApb); #1;
      end
    end
    if (got) begin
      @(posedge ckApb); #1;
    end
    selA[d] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int cyc;
    bit got;

    srstApb = 1'b1; paddr = '0; pprot = '0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0;
    for (int i = 0; i < 3; i++) selA[i] = 1'b0;
    repeat (3) @(posedge ckApb);
    #1 srstApb = 1'b0;
    @(negedge ckApb);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(readyA[i]), 0);
      check($sformatf("rst_err%0d", i),   32'(errA[i]),   0);
      check($sformatf("rst_rdata%0d", i), rdataA[i],      0);
      check($sformatf("rst_pulse%0d", i), 32'(pulseA[i]), 0);
      check($sformatf("rst_regq%0d", i),  32'(|regQA[i]), 0);
    end

    vecs.push_back('{0, 1'b0, 32'h0000_000C, 32'h0,         4'h0,    3'b000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 4'b0101, 3'b000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 32'h0000_0014, 32'h0,         4'h0,    3'b000, 32'h00AD_00EF, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 32'h0000_0040, 32'h0,         4'h0,    3'b000, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{0, 1'b0, 32'h8000_0014, 32'h0,         4'h0,    3'b000, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF,    3'b000, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         4'h0,    3'b000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF,    3'b001, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         4'h0,    3'b000, 32'hA5A5_A5A5, 1'b0, 1});
    vecs.push_back('{0, 1'b1, 32'h0000_003C, 32'h1122_3344, 4'hF,    3'b000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 32'h0000_003F, 32'h0,         4'h0,    3'b000, 32'h1122_3344, 1'b0, 1});
    vecs.push_back('{0, 1'b1, 32'h0000_0018, 32'hFFFF_FFFF, 4'h0,    3'b000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 32'h0000_0018, 32'h0,         4'h0,    3'b000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{0, 1'b1, 32'h0000_0014, 32'h1234_5678, 4'b1000, 3'b000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 32'h0000_0014, 32'h0,         4'h0,    3'b000, 32'h12AD_00EF, 1'b0, 1});
    vecs.push_back('{1, 1'b1, 32'h0000_0018, 32'hCAFE_F00D, 4'hF,    3'b000, 32'h0000_0000, 1'b0, 4});
    vecs.push_back('{1, 1'b0, 32'h0000_0018, 32'h0,         4'h0,    3'b000, 32'hCAFE_F00D, 1'b0, 4});
    vecs.push_back('{2, 1'b0, 32'h0000_0018, 32'h0,         4'h0,    3'b000, 32'h0000_0000, 1'b0, 3});
    vecs.push_back('{2, 1'b0, 32'h0000_0044, 32'h0,         4'h0,    3'b000, 32'h0000_0000, 1'b1, 3});

    foreach (vecs[i]) begin
      apbXfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
              rd, er, cyc, got);
      check($sformatf("v%0d_done", i), 32'(got), 1);
      check($sformatf("v%0d_data", i), rd, vecs[i].expData);
      check($sformatf("v%0d_err", i),  32'(er), 32'(vecs[i].expErr));
      check($sformatf("v%0d_cyc", i),  cyc, vecs[i].expCyc);
    end

    // Write pulse lasts exactly one cycle after commit
    apbXfer(0, 1'b1, 32'h1C, 32'h0102_0304, 4'hF, 3'b000, rd, er, cyc, got);
    @(negedge ckApb);
    check("pulse_hi", 32'(pulseA[0]), 32'h0080);
    check("pulse_regq7", regQA[0][7*32 +: 32], 32'h0102_0304);
    @(negedge ckApb);
    check("pulse_lo", 32'(pulseA[0]), 0);

    // Zero-strobe write: OKAY, no change, no pulse
    apbXfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 3'b000, rd, er, cyc, got);
    check("nostrb_err", 32'(er), 0);
    @(negedge ckApb);
    check("nostrb_pulse", 32'(pulseA[0]), 0);
    check("nostrb_regq8", regQA[0][8*32 +: 32], 0);

    // Three wait states: ready only in the fourth access cycle, commit at its end
    setup(1, 1'b1, 32'h04, 32'h55AA_55AA, 4'hF, 3'b000);
    for (int c = 1; c <= 4; c++) begin
      @(negedge ckApb);
      check($sformatf("w3_ready_c%0d", c), 32'(readyA[1]), (c == 4) ? 1 : 0);
      check($sformatf("w3_regq_c%0d", c), regQA[1][1*32 +: 32], 0);
      if (c < 4) begin
        @(posedge ckApb); #1;
      end
    end
    @(posedge ckApb); #1;
    selA[1] = 1'b0; penable = 1'b0;
    @(negedge ckApb);
    check("w3_regq_after", regQA[1][1*32 +: 32], 32'h55AA_55AA);
    check("w3_pulse", 32'(pulseA[1]), 32'h0002);

    // Abort mid-wait: select dropped after the first access cycle
    setup(2, 1'b1, 32'h0C, 32'h7777_7777, 4'hF, 3'b000);
    @(negedge ckApb);
    check("abort_ready_c1", 32'(readyA[2]), 0);
    @(posedge ckApb); #1;
    selA[2] = 1'b0; penable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ckApb);
      check($sformatf("abort_ready_%0d", c), 32'(readyA[2]), 0);
      check($sformatf("abort_pulse_%0d", c), 32'(pulseA[2]), 0);
      check($sformatf("abort_regq_%0d", c),  regQA[2][3*32 +: 32], 0);
    end
    apbXfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, rd, er, cyc, got);
    check("abort_rd_data", rd, 0);
    check("abort_rd_cyc", cyc, 3);
    apbXfer(2, 1'b1, 32'h0C, 32'h7777_7777, 4'hF, 3'b000, rd, er, cyc, got);
    check("abort_wr_cyc", cyc, 3);
    apbXfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, rd, er, cyc, got);
    check("abort_rd2_data", rd, 32'h7777_7777);

    // Reset asserted across the completing edge of a write
    setup(0, 1'b1, 32'h08, 32'h1234_5678, 4'hF, 3'b000);
    srstApb = 1'b1;
    @(negedge ckApb);
    check("rstmid_ready", 32'(readyA[0]), 1);
    @(posedge ckApb); #1;
    srstApb = 1'b0; selA[0] = 1'b0; penable = 1'b0;
    @(negedge ckApb);
    check("rstmid_ready_after", 32'(readyA[0]), 0);
    check("rstmid_err", 32'(errA[0]), 0);
    check("rstmid_rdata", rdataA[0], 0);
    check("rstmid_pulse", 32'(pulseA[0]), 0);
    check("rstmid_regq0", 32'(|regQA[0]), 0);
    check("rstmid_regq3", 32'(|regQA[1]), 0);
    apbXfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, cyc, got);
    check("rstmid_rd_done", 32'(got), 1);
    check("rstmid_rd_data", rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
